exec_monitor: RTL and testbench

- Execution-protection monitor directly upstream of the CPU memory decode/mux.
- Watches the CPU bus (cpu_valid, cpu_instr, cpu_addr) and drives force_trap, so the mux returns the illegal instruction 32'h0 instead of issuing the access.
- Firmware or the app configures one inclusive address window through an MMIO register slot. Once armed, the window is locked until reset.
- Any instruction fetch inside the armed window causes a sticky trap.

---
 rtl/tk1_mmio_pkg.sv | 24 ++
 rtl/exec_monitor_range_cmp.sv | 13 +
 rtl/exec_monitor.sv | 137 +++++++++++++
 tb/tb_exec_monitor.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/tk1_mmio_pkg.sv
// Shared MMIO register map, monitor state encodings and the illegal-instruction constant.
package tk1_mmio_pkg;

  localparam int unsigned MMIO_ADDR_W = 8;
  localparam int unsigned MMIO_DATA_W = 32;

  localparam logic [MMIO_ADDR_W-1:0] ADDR_VERSION   = 8'h00;
  localparam logic [MMIO_ADDR_W-1:0] ADDR_CTRL      = 8'h08;
  localparam logic [MMIO_ADDR_W-1:0] ADDR_STATUS    = 8'h09;
  localparam logic [MMIO_ADDR_W-1:0] ADDR_FIRST     = 8'h10;
  localparam logic [MMIO_ADDR_W-1:0] ADDR_LAST      = 8'h11;
  localparam logic [MMIO_ADDR_W-1:0] ADDR_HIT_ADDR  = 8'h12;
  localparam logic [MMIO_ADDR_W-1:0] ADDR_HIT_COUNT = 8'h13;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'h0,
    ST_ARMED   = 2'h1,
    ST_TRAPPED = 2'h2
  } mon_state_e;

  // Word the CPU mux substitutes for a trapped access.
  localparam logic [MMIO_DATA_W-1:0] ILLEGAL_INSTRUCTION = 32'h0;

endpackage

// File: rtl/exec_monitor_range_cmp.sv
// Inclusive unsigned window compare; an inverted window (first > last) never matches.
module exec_monitor_range_cmp
  import tk1_mmio_pkg::*;
(
  input  logic [MMIO_DATA_W-1:0] addr,
  input  logic [MMIO_DATA_W-1:0] first,
  input  logic [MMIO_DATA_W-1:0] last,
  output logic                   in_window_c
);

  assign in_window_c = (addr >= first) && (addr <= last);

endmodule

// File: rtl/exec_monitor.sv
// Execution-protection monitor: traps CPU accesses into a lockable address window.
// Define EXEC_MONITOR_DATA_EN to trap data accesses in the window as well as fetches.
module exec_monitor
  import tk1_mmio_pkg::*;
#(
  parameter logic [31:0] VERSION = 32'h0000_0001,
  parameter int unsigned COUNT_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_valid,
  input  logic        cpu_instr,
  input  logic [31:0] cpu_addr,
  output logic        force_trap,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready
);

`ifdef EXEC_MONITOR_DATA_EN
  localparam logic DATA_EN = 1'b1;
`else
  localparam logic DATA_EN = 1'b0;
`endif

  mon_state_e         state;
  mon_state_e         state_next;
  logic [31:0]        first_addr;
  logic [31:0]        last_addr;
  logic [31:0]        hit_addr;
  logic [COUNT_W-1:0] hit_count;
  logic               cpu_valid_prev;

  logic               in_window_c;
  logic               access_match_c;
  logic               hit_c;
  logic               new_req_c;
  logic               wr_c;
  logic               arm_wr_c;
  logic [31:0]        rdata_c;

  exec_monitor_range_cmp u_range_cmp (
    .addr        (cpu_addr),
    .first       (first_addr),
    .last        (last_addr),
    .in_window_c (in_window_c)
  );

`ifdef EXEC_MONITOR_DATA_EN
  assign access_match_c = cpu_valid;
`else
  assign access_match_c = cpu_valid & cpu_instr;
`endif

  assign hit_c     = access_match_c & in_window_c;
  assign new_req_c = cpu_valid & ~cpu_valid_prev;
  assign wr_c      = cs & we;
  assign arm_wr_c  = wr_c & (address == ADDR_CTRL) & write_data[0];

  // Gated by reset_n so the trap drops within the reset cycle itself.
  assign force_trap = reset_n &
                      ((state == ST_TRAPPED) | ((state == ST_ARMED) & hit_c));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:    if (arm_wr_c) state_next = ST_ARMED;
      ST_ARMED:   if (hit_c) state_next = ST_TRAPPED;
      ST_TRAPPED: state_next = ST_TRAPPED;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Window is only configurable before arming.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      first_addr <= '0;
      last_addr  <= '0;
    end else if ((state == ST_IDLE) && wr_c) begin
      if (address == ADDR_FIRST) first_addr <= write_data;
      if (address == ADDR_LAST)  last_addr  <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit_addr       <= '0;
      hit_count      <= '0;
      cpu_valid_prev <= 1'b0;
    end else begin
      cpu_valid_prev <= cpu_valid;
      if ((state == ST_ARMED) && hit_c) begin
        hit_addr <= cpu_addr;
      end
      // One count per new violating request, saturating.
      if ((state != ST_IDLE) && hit_c && new_req_c && (hit_count != '1)) begin
        hit_count <= hit_count + COUNT_W'(1);
      end
    end
  end

  always_comb begin
    rdata_c = '0;
    unique case (address)
      ADDR_VERSION:   rdata_c = VERSION;
      ADDR_STATUS:    rdata_c = {29'h0, DATA_EN, (state == ST_TRAPPED),
                                 (state != ST_IDLE)};
      ADDR_FIRST:     rdata_c = first_addr;
      ADDR_LAST:      rdata_c = last_addr;
      ADDR_HIT_ADDR:  rdata_c = hit_addr;
      ADDR_HIT_COUNT: rdata_c = 32'(hit_count);
      default:        rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ready     <= 1'b0;
      read_data <= '0;
    end else begin
      ready     <= cs;
      read_data <= (cs && !we) ? rdata_c : '0;
    end
  end

endmodule

// File: tb/tb_exec_monitor.sv
// Directed self-checking bench for exec_monitor with a read-data scoreboard queue.
module tb_exec_monitor;
  import tk1_mmio_pkg::*;

`ifdef EXEC_MONITOR_DATA_EN
  localparam logic [31:0] STATUS_BASE = 32'h4;
  localparam logic        DATA_TRAP   = 1'b1;
`else
  localparam logic [31:0] STATUS_BASE = 32'h0;
  localparam logic        DATA_TRAP   = 1'b0;
`endif

  localparam logic [31:0] WIN_FIRST = 32'h4000_1000;
  localparam logic [31:0] WIN_LAST  = 32'h4000_10FF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_valid;
  logic        cpu_instr;
  logic [31:0] cpu_addr;
  logic        force_trap;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  exec_monitor #(.VERSION(32'h0000_0001), .COUNT_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_valid  (cpu_valid),
    .cpu_instr  (cpu_instr),
    .cpu_addr   (cpu_addr),
    .force_trap (force_trap),
    .cs         (cs),
    .we         (we),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; cpu_valid = 1'b0; cpu_instr = 1'b0; cpu_addr = '0;
    cs = 1'b0; we = 1'b0; address = '0; write_data = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic mmio_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; address = a; write_data = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
    check("wr_ready", 32'(ready), 32'h1);
  endtask

  // Push the expectation on the request, pop it when ready comes back.
  task automatic mmio_read(input string tag, input logic [7:0] a, input logic [31:0] exp);
    int n;
    @(negedge clk);
    cs = 1'b1; we = 1'b0; address = a;
    exp_q.push_back(exp);
    @(negedge clk);
    cs = 1'b0;
    n = 0;
    while (ready !== 1'b1 && n < 4) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      check({tag, "_ready_timeout"}, 32'(ready), 32'h1);
      void'(exp_q.pop_front());
    end else begin
      check(tag, read_data, exp_q.pop_front());
    end
  endtask

  // One-cycle request followed by an idle cycle so the next call is a new request.
  task automatic fetch(input string tag, input logic [31:0] a, input logic instr,
                       input logic exp_trap);
    @(negedge clk);
    cpu_valid = 1'b1; cpu_instr = instr; cpu_addr = a;
    #1;
    check(tag, 32'(force_trap), 32'(exp_trap));
    @(negedge clk);
    cpu_valid = 1'b0; cpu_instr = 1'b0;
  endtask

  task automatic config_and_arm();
    mmio_write(ADDR_FIRST, WIN_FIRST);
    mmio_write(ADDR_LAST, WIN_LAST);
    mmio_write(ADDR_CTRL, 32'h1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset values and ID/status reads
    do_reset();
    #1;
    check("rst_force_trap", 32'(force_trap), 32'h0);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_read_data", read_data, 32'h0);
    mmio_read("version", ADDR_VERSION, 32'h0000_0001);
    mmio_read("status_idle", ADDR_STATUS, STATUS_BASE);
    mmio_read("ctrl_reads_zero", ADDR_CTRL, 32'h0);
    mmio_read("unmapped", 8'h55, 32'h0);

    // 2: arm with a simultaneous in-window fetch, then fetch just past LAST
    mmio_write(ADDR_FIRST, WIN_FIRST);
    mmio_write(ADDR_LAST, WIN_LAST);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; address = ADDR_CTRL; write_data = 32'h1;
    cpu_valid = 1'b1; cpu_instr = 1'b1; cpu_addr = WIN_FIRST;
    #1;
    check("arm_same_cycle_fetch", 32'(force_trap), 32'h0);
    @(negedge clk);
    cs = 1'b0; we = 1'b0; cpu_valid = 1'b0; cpu_instr = 1'b0;
    mmio_read("status_armed", ADDR_STATUS, STATUS_BASE | 32'h1);
    fetch("fetch_past_last", 32'h4000_1100, 1'b1, 1'b0);
    fetch("fetch_below_first", 32'h4000_0FFC, 1'b1, 1'b0);

    // 3: violating fetch traps immediately and sticks
    fetch("fetch_in_window", 32'h4000_10FC, 1'b1, 1'b1);
    #1;
    check("trap_sticky", 32'(force_trap), 32'h1);
    mmio_read("status_trapped", ADDR_STATUS, STATUS_BASE | 32'h3);
    mmio_read("hit_addr", ADDR_HIT_ADDR, 32'h4000_10FC);
    mmio_read("hit_count_one", ADDR_HIT_COUNT, 32'h1);

    // 4: window locked once armed; empty window never hits
    do_reset();
    config_and_arm();
    mmio_write(ADDR_FIRST, 32'h0);
    mmio_read("first_locked", ADDR_FIRST, WIN_FIRST);
    do_reset();
    mmio_write(ADDR_FIRST, 32'h10);
    mmio_write(ADDR_LAST, 32'h8);
    mmio_read("last_readback", ADDR_LAST, 32'h8);
    mmio_write(ADDR_CTRL, 32'h1);
    fetch("empty_win_8", 32'h8, 1'b1, 1'b0);
    fetch("empty_win_10", 32'h10, 1'b1, 1'b0);
    mmio_read("status_empty_win", ADDR_STATUS, STATUS_BASE | 32'h1);

    // 5: data access inside the window
    do_reset();
    mmio_write(ADDR_CTRL, 32'h0);
    mmio_read("arm_bit0_zero", ADDR_STATUS, STATUS_BASE);
    config_and_arm();
    fetch("data_access", 32'h4000_1004, 1'b0, DATA_TRAP);
    mmio_read("status_data", ADDR_STATUS,
              STATUS_BASE | (DATA_TRAP ? 32'h3 : 32'h1));

    // 6: saturating count, then reset out of TRAPPED
    do_reset();
    config_and_arm();
    fetch("sat_first", WIN_FIRST, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      fetch("sat_loop", WIN_LAST, 1'b1, 1'b1);
    end
    mmio_read("hit_count_sat", ADDR_HIT_COUNT, 32'hF);
    mmio_read("hit_addr_first_only", ADDR_HIT_ADDR, WIN_FIRST);
    @(negedge clk);
    reset_n = 1'b0; cpu_valid = 1'b1; cpu_instr = 1'b1; cpu_addr = WIN_FIRST;
    #1;
    check("trap_falls_in_reset", 32'(force_trap), 32'h0);
    @(negedge clk);
    reset_n = 1'b1; cpu_valid = 1'b0; cpu_instr = 1'b0;
    #1;
    check("trap_after_reset", 32'(force_trap), 32'h0);
    mmio_read("status_after_reset", ADDR_STATUS, STATUS_BASE);
    mmio_read("count_after_reset", ADDR_HIT_COUNT, 32'h0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
